uart_tx_ctrl: RTL and testbench

//  Transmit-side controller that sits directly upstream of the Tx shift register.
//  - Pops bytes from the Tx FIFO and latches each byte.
//  - Computes the parity bit.
//  - Issues one load_en per frame, then one shift_en per bit period from an internal baud counter.
//  - Frame on the line: start(0), d0..d7, parity, stop(1); 11 bit periods total.

---
 rtl/uart_pkg.sv | 18 +
 rtl/uart_baud_counter.sv | 27 ++
 rtl/uart_tx_ctrl.sv | 130 +++++++++++++
 tb/tb_uart_tx_ctrl.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and frame constants for the UART transmit path.
package uart_pkg;

    typedef enum logic [2:0] {
        TX_INIT,
        TX_IDLE,
        TX_FETCH,
        TX_LOAD,
        TX_SEND
    } tx_state_e;

    // Payload width, baud ticks per frame (start + 8 data + parity + stop),
    // and the number of those ticks that advance the shift register.
    localparam int UART_DATA_W      = 8;
    localparam int UART_FRAME_TICKS = 11;
    localparam int UART_SHIFT_TICKS = 10;

endpackage

// File: rtl/uart_baud_counter.sv
// Bit-period counter: counts 0..div while enabled and raises tick for the
// single cycle in which the count equals div, then wraps to zero.
module uart_baud_counter #(
    parameter int DIV_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             en,
    input  logic [DIV_W-1:0] div,
    output logic             tick
);

    logic [DIV_W-1:0] cnt;

    assign tick = en && (cnt == div);

    // Count up while enabled; wrap on tick, restart on clear or reset.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= tick ? '0 : cnt + DIV_W'(1);
        end
    end

endmodule

// File: rtl/uart_tx_ctrl.sv
// UART transmit controller: pops bytes from the Tx FIFO, latches byte and
// parity, then paces the downstream shift register with one load strobe and
// ten shift strobes per 11-bit frame (start, d0..d7, parity, stop).
// Optional feature macro: UART_TX_PARITY_EN. When undefined the parity slot
// carries a constant 1 (acts as a second stop bit) and parity_odd is unused.
module uart_tx_ctrl
    import uart_pkg::*;
#(
    parameter int DIV_W = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   tx_en,
    input  logic [DIV_W-1:0]       baud_div,
    input  logic                   parity_odd,
    input  logic                   fifo_empty,
    input  logic [UART_DATA_W-1:0] fifo_data,
    output logic                   fifo_rd_en,
    output logic [UART_DATA_W-1:0] tx_data,
    output logic                   parity_bit,
    output logic                   load_en,
    output logic                   shift_en,
    output logic                   tx_busy,
    output logic                   tx_done
);

    tx_state_e        state;
    tx_state_e        state_nxt;
    logic [DIV_W-1:0] div_q;
    logic [3:0]       bit_cnt;
    logic             tick;
    logic             last_tick;
    logic             pop_req;
    logic             parity_nxt;

`ifdef UART_TX_PARITY_EN
    function automatic logic calc_parity(input logic [UART_DATA_W-1:0] b,
                                         input logic odd);
        return odd ? ~^b : ^b;
    endfunction

    assign parity_nxt = calc_parity(fifo_data, parity_odd);
`else
    logic parity_odd_unused;
    assign parity_odd_unused = parity_odd;
    assign parity_nxt        = 1'b1;
`endif

    // The baud counter is cleared while loading so the start bit gets a
    // full period, and only runs while the frame is on the line.
    uart_baud_counter #(
        .DIV_W (DIV_W)
    ) u_baud (
        .clk   (clk),
        .reset (reset),
        .clear (state == TX_LOAD),
        .en    (state == TX_SEND),
        .div   (div_q),
        .tick  (tick)
    );

    // bit_cnt holds the number of ticks already seen, so the eleventh tick
    // arrives with bit_cnt at FRAME_TICKS-1.
    assign last_tick = tick && (bit_cnt == 4'(UART_FRAME_TICKS - 1));
    assign pop_req   = tx_en && !fifo_empty;

    // Next-state decode; the FIFO pop is a Mealy output of IDLE.
    always_comb begin
        state_nxt  = state;
        fifo_rd_en = 1'b0;
        case (state)
            TX_INIT:  state_nxt = TX_IDLE;
            TX_IDLE: begin
                if (pop_req) begin
                    fifo_rd_en = !reset;
                    state_nxt  = TX_FETCH;
                end
            end
            TX_FETCH: state_nxt = TX_LOAD;
            TX_LOAD:  state_nxt = TX_SEND;
            TX_SEND: begin
                if (last_tick) begin
                    state_nxt = TX_IDLE;
                end
            end
            default:  state_nxt = TX_INIT;
        endcase
    end

    // Strobes are held low while reset is asserted so an aborted frame
    // cannot pop, load or shift; the INIT shift fires once reset releases
    // and drives the freshly reset (low) line bit high.
    assign load_en  = !reset && (state == TX_LOAD);
    assign shift_en = !reset &&
                      ((state == TX_INIT) ||
                       ((state == TX_SEND) && tick &&
                        (bit_cnt < 4'(UART_SHIFT_TICKS))));
    assign tx_done  = !reset && (state == TX_SEND) && last_tick;
    assign tx_busy  = (state == TX_FETCH) || (state == TX_LOAD) ||
                      (state == TX_SEND);

    // Control state: FSM, divisor snapshot and tick counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= TX_INIT;
            div_q   <= '0;
            bit_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (state == TX_LOAD) begin
                div_q   <= baud_div;
                bit_cnt <= '0;
            end else if ((state == TX_SEND) && tick) begin
                bit_cnt <= bit_cnt + 4'd1;
            end
        end
    end

    // Byte and parity capture; FIFO read data is valid during FETCH.
    always_ff @(posedge clk) begin
        if (reset) begin
            tx_data    <= '0;
            parity_bit <= 1'b1;
        end else if (state == TX_FETCH) begin
            tx_data    <= fifo_data;
            parity_bit <= parity_nxt;
        end
    end

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Directed testbench for uart_tx_ctrl with a small behavioural Tx FIFO.
// Honours UART_TX_PARITY_EN for the expected parity values.
module tb_uart_tx_ctrl;

    logic        clk;
    logic        reset;
    logic        tx_en;
    logic [15:0] baud_div;
    logic        parity_odd;
    logic        fifo_empty;
    logic [7:0]  fifo_data;
    logic        fifo_rd_en;
    logic [7:0]  tx_data;
    logic        parity_bit;
    logic        load_en;
    logic        shift_en;
    logic        tx_busy;
    logic        tx_done;

    int n_checks = 0;
    int n_fail   = 0;

`ifdef UART_TX_PARITY_EN
    localparam logic P_A5 = 1'b0;  // 4 ones, even parity
    localparam logic P_01 = 1'b0;  // 1 one, odd parity
    localparam logic P_AA = 1'b0;  // 4 ones, even parity
`else
    localparam logic P_A5 = 1'b1;
    localparam logic P_01 = 1'b1;
    localparam logic P_AA = 1'b1;
`endif

    uart_tx_ctrl #(.DIV_W(16)) dut (
        .clk        (clk),
        .reset      (reset),
        .tx_en      (tx_en),
        .baud_div   (baud_div),
        .parity_odd (parity_odd),
        .fifo_empty (fifo_empty),
        .fifo_data  (fifo_data),
        .fifo_rd_en (fifo_rd_en),
        .tx_data    (tx_data),
        .parity_bit (parity_bit),
        .load_en    (load_en),
        .shift_en   (shift_en),
        .tx_busy    (tx_busy),
        .tx_done    (tx_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural FIFO: data appears the cycle after a pop.
    logic [7:0] fmem [16];
    int         wr_p = 0;
    int         rd_p = 0;
    int         bad_pop = 0;

    assign fifo_empty = (wr_p == rd_p);

    always @(posedge clk) begin
        if (fifo_rd_en) begin
            fifo_data <= fmem[rd_p];
            rd_p      <= rd_p + 1;
        end
    end

    always @(negedge clk) begin
        if (fifo_rd_en && fifo_empty) bad_pop++;
    end

    task automatic push(input logic [7:0] b);
        fmem[wr_p] = b;
        wr_p++;
    endtask

    task automatic check_eq(input string tag, input logic [31:0] got,
                            input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Frame capture results, indexed relative to the cycle of the pop.
    int   load_t, done_t, done_n, shift_n, rd_n, busy_n, overlap;
    int   shift_t [32];
    int   rd_t [8];
    logic [7:0] data_t5;

    task automatic wait_rd(input string tag);
        bit ok;
        ok = 0;
        #1;
        for (int i = 0; i < 40; i++) begin
            if (fifo_rd_en) begin
                ok = 1;
                break;
            end
            @(negedge clk);
        end
        check_eq(tag, 32'(ok), 32'd1);
    endtask

    task automatic capture(input int ncyc, input int drop_at);
        load_t = -1; done_t = -1; done_n = 0; shift_n = 0;
        rd_n = 0; busy_n = 0; overlap = 0; data_t5 = 8'h00;
        for (int t = 0; t < ncyc; t++) begin
            if (t > 0) @(negedge clk);
            if (load_en && load_t < 0) load_t = t;
            if (shift_en) begin
                if (shift_n < 32) shift_t[shift_n] = t;
                shift_n++;
            end
            if (tx_done) begin
                if (done_t < 0) done_t = t;
                done_n++;
            end
            if (fifo_rd_en) begin
                if (rd_n < 8) rd_t[rd_n] = t;
                rd_n++;
            end
            if (tx_busy) busy_n++;
            if (load_en && shift_en) overlap++;
            if (t == 5) data_t5 = tx_data;
            if (t == drop_at) begin
                tx_en    = 1'b0;
                baud_div = 16'd7;
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset      = 1'b1;
        tx_en      = 1'b0;
        baud_div   = 16'd3;
        parity_odd = 1'b0;
        fifo_data  = 8'h00;

        // Reset values, then one INIT shift pulse, then idle.
        @(negedge clk);
        check_eq("rst_strobes", {27'd0, fifo_rd_en, load_en, shift_en, tx_busy, tx_done}, 32'd0);
        check_eq("rst_tx_data", 32'(tx_data), 32'h00);
        check_eq("rst_parity", 32'(parity_bit), 32'd1);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        #1;
        check_eq("init_shift", 32'(shift_en), 32'd1);
        @(negedge clk);
        check_eq("idle_shift", 32'(shift_en), 32'd0);
        check_eq("idle_busy", 32'(tx_busy), 32'd0);

        // Single byte A5, div 3, even parity.
        baud_div = 16'd3; parity_odd = 1'b0;
        push(8'hA5); tx_en = 1'b1;
        wait_rd("a5_pop_seen");
        capture(50, -1);
        check_eq("a5_rd_n", 32'(rd_n), 32'd1);
        check_eq("a5_load_t", 32'(load_t), 32'd2);
        check_eq("a5_shift_n", 32'(shift_n), 32'd10);
        check_eq("a5_shift_first", 32'(shift_t[0]), 32'd6);
        check_eq("a5_shift_second", 32'(shift_t[1]), 32'd10);
        check_eq("a5_shift_last", 32'(shift_t[9]), 32'd42);
        check_eq("a5_done_t", 32'(done_t), 32'd46);
        check_eq("a5_done_n", 32'(done_n), 32'd1);
        check_eq("a5_busy_n", 32'(busy_n), 32'd46);
        check_eq("a5_overlap", 32'(overlap), 32'd0);
        check_eq("a5_tx_data", 32'(tx_data), 32'hA5);
        check_eq("a5_parity", 32'(parity_bit), 32'(P_A5));

        // Byte 01 with odd parity selected.
        parity_odd = 1'b1;
        push(8'h01);
        wait_rd("p01_pop_seen");
        capture(50, -1);
        check_eq("p01_tx_data", 32'(tx_data), 32'h01);
        check_eq("p01_parity", 32'(parity_bit), 32'(P_01));
        check_eq("p01_done_t", 32'(done_t), 32'd46);

        // Back-to-back 55, AA at div 0.
        parity_odd = 1'b0; baud_div = 16'd0;
        push(8'h55); push(8'hAA);
        wait_rd("b2b_pop_seen");
        capture(40, -1);
        check_eq("b2b_rd_n", 32'(rd_n), 32'd2);
        check_eq("b2b_done_first", 32'(done_t), 32'd13);
        check_eq("b2b_rd_second", 32'(rd_t[1]), 32'd14);
        check_eq("b2b_done_n", 32'(done_n), 32'd2);
        check_eq("b2b_shift_n", 32'(shift_n), 32'd20);
        check_eq("b2b_shift_first", 32'(shift_t[0]), 32'd3);
        check_eq("b2b_shift_f2_first", 32'(shift_t[10]), 32'd17);
        check_eq("b2b_overlap", 32'(overlap), 32'd0);
        check_eq("b2b_data_first", 32'(data_t5), 32'h55);
        check_eq("b2b_data_second", 32'(tx_data), 32'hAA);
        check_eq("b2b_parity", 32'(parity_bit), 32'(P_AA));

        // tx_en drop and baud_div 3->7 mid-frame.
        baud_div = 16'd3;
        push(8'h3C); push(8'hC3);
        wait_rd("drop_pop_seen");
        capture(60, 10);
        check_eq("drop_rd_n", 32'(rd_n), 32'd1);
        check_eq("drop_shift_n", 32'(shift_n), 32'd10);
        check_eq("drop_shift_last", 32'(shift_t[9]), 32'd42);
        check_eq("drop_done_t", 32'(done_t), 32'd46);
        check_eq("drop_fifo_left", 32'(fifo_empty), 32'd0);

        // Reset around bit 5 of a frame (div 3).
        baud_div = 16'd3; tx_en = 1'b1;
        wait_rd("rst_pop_seen");
        repeat (26) @(negedge clk);
        check_eq("mid_busy_before", 32'(tx_busy), 32'd1);
        reset = 1'b1; tx_en = 1'b0;
        @(negedge clk);
        check_eq("mid_rst_strobes", {27'd0, fifo_rd_en, load_en, shift_en, tx_busy, tx_done}, 32'd0);
        check_eq("mid_rst_tx_data", 32'(tx_data), 32'h00);
        check_eq("mid_rst_parity", 32'(parity_bit), 32'd1);
        reset = 1'b0;
        #1;
        check_eq("mid_init_shift", 32'(shift_en), 32'd1);
        @(negedge clk);
        capture(40, -1);
        check_eq("mid_no_done", 32'(done_n), 32'd0);
        check_eq("mid_no_shift", 32'(shift_n), 32'd0);
        check_eq("mid_no_busy", 32'(busy_n), 32'd0);
        check_eq("mid_no_pop", 32'(rd_n), 32'd0);

        check_eq("no_pop_when_empty", 32'(bad_pop), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
